zynq_packetizer: RTL and testbench

//  Sits between the digitizer output FIFO (GLBL fifo in digi_many) and the ZYNQ link.

---
 rtl/zynq_packetizer.sv | 121 ++++++++++++
 tb/tb_zynq_packetizer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zynq_packetizer.sv
// Frames 12-bit digitizer FIFO words into header/data/trailer/checksum packets
// on a 16-bit valid/ready stream towards the ZYNQ DMA bridge.
module zynq_packetizer #(
    parameter int WIDTH     = 12,
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 64
) (
    input  logic             CK50,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] FIFO_DOUT,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RDREQ,
    output logic [15:0]      TX_DATA,
    output logic             TX_VALID,
    input  logic             TX_READY,
    output logic             TX_LAST,
    output logic [7:0]       SEQ,
    output logic             BUSY
);

    localparam int              IW   = $clog2(TIMEOUT + 1);
    localparam logic [12:0]     MAXW = 13'(MAX_WORDS);
    localparam logic [IW-1:0]   TMO  = IW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_TRL, S_CSUM} state_t;

    state_t           state, state_nx;
    logic [11:0]      cnt;
    logic [IW-1:0]    idle_ctr;
    logic [WIDTH-1:0] hold;
    logic             hold_v;
    logic             pend;
    logic [15:0]      csum;
    logic [7:0]       seq;
    logic [12:0]      fill;
    logic             close;
    logic             rd;
    logic             beat;

    // Words already committed to this packet, including the one in flight.
    assign fill  = {1'b0, cnt} + 13'(pend) + 13'(hold_v);
    assign close = !pend && !hold_v && (fill == MAXW || idle_ctr == TMO);
    assign rd    = (state == S_DATA) && !FIFO_EMPTY && !pend && !hold_v
                   && (fill < MAXW) && !close;

    assign FIFO_RDREQ = rd;
    assign beat       = TX_VALID && TX_READY;
    assign SEQ        = seq;
    assign BUSY       = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        TX_DATA  = 16'h0000;
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ENABLE && !FIFO_EMPTY) state_nx = S_HDR;
            end
            S_HDR: begin
                TX_DATA  = {8'hA5, seq};
                TX_VALID = 1'b1;
                if (TX_READY) state_nx = S_DATA;
            end
            S_DATA: begin
                TX_DATA  = {{(16-WIDTH){1'b0}}, hold};
                TX_VALID = hold_v;
                if (close) state_nx = S_TRL;
            end
            S_TRL: begin
                TX_DATA  = {4'hE, cnt};
                TX_VALID = 1'b1;
                if (TX_READY) state_nx = S_CSUM;
            end
            S_CSUM: begin
                TX_DATA  = csum;
                TX_VALID = 1'b1;
                TX_LAST  = 1'b1;
                if (TX_READY) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CK50) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idle_ctr <= '0;
            hold     <= '0;
            hold_v   <= 1'b0;
            pend     <= 1'b0;
            csum     <= 16'h0000;
            seq      <= 8'h00;
        end else begin
            state <= state_nx;
            pend  <= rd;
            if (pend) begin
                hold   <= FIFO_DOUT;
                hold_v <= 1'b1;
            end else if (state == S_DATA && beat) begin
                hold_v <= 1'b0;
            end
            if (state == S_DATA && beat) cnt <= cnt + 12'd1;
            if (beat && state != S_CSUM) csum <= csum ^ TX_DATA;
            // Idle run only counts cycles where nothing is in flight, so a stalled sink does not close the packet.
            if (rd)
                idle_ctr <= '0;
            else if (state == S_DATA && FIFO_EMPTY && !pend && !hold_v && idle_ctr != TMO)
                idle_ctr <= idle_ctr + 1'b1;
            if (state == S_CSUM && beat) begin
                seq      <= seq + 8'd1;
                cnt      <= '0;
                idle_ctr <= '0;
                csum     <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_zynq_packetizer.sv
// Directed bench for zynq_packetizer: FIFO model, stream scoreboard and
// handshake-stability monitor.
module tb_zynq_packetizer;

    localparam int MAXW = 4;
    localparam int TMO  = 8;

    logic        CK50 = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic [11:0] FIFO_DOUT = 12'h000;
    logic        FIFO_EMPTY = 1'b1;
    logic        FIFO_RDREQ;
    logic [15:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic        TX_LAST;
    logic [7:0]  SEQ;
    logic        BUSY;

    zynq_packetizer #(.WIDTH(12), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
        .CK50(CK50), .RST(RST), .ENABLE(ENABLE), .FIFO_DOUT(FIFO_DOUT),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RDREQ(FIFO_RDREQ), .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_LAST(TX_LAST),
        .SEQ(SEQ), .BUSY(BUSY)
    );

    initial forever #5 CK50 = ~CK50;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] fifo[$];
    logic [11:0] pw[$];
    logic [16:0] exp_q[$];
    logic [7:0]  exp_seq = 8'h00;
    logic        rand_rdy = 1'b0;
    logic        mon_en = 1'b1;
    logic        rd_q = 1'b0;
    logic        stall_q = 1'b0;
    logic [15:0] stall_data = 16'h0;
    logic        stall_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // FIFO model plus stream monitor, all evaluated away from the rising edge.
    initial forever begin
        @(negedge CK50);
        if (rd_q && fifo.size() > 0) FIFO_DOUT = fifo.pop_front();
        FIFO_EMPTY = (fifo.size() == 0);
        #1;
        rd_q = FIFO_RDREQ;
        if (FIFO_RDREQ) check("rdreq_while_empty", {31'd0, FIFO_EMPTY}, 32'd0);
        if (mon_en) begin
            if (stall_q) begin
                check("stall_valid", {31'd0, TX_VALID}, 32'd1);
                check("stall_data", {16'd0, TX_DATA}, {16'd0, stall_data});
                check("stall_last", {31'd0, TX_LAST}, {31'd0, stall_last});
            end
            if (TX_VALID && TX_READY) begin
                check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("tx_data", {16'd0, TX_DATA}, {16'd0, e[15:0]});
                    check("tx_last", {31'd0, TX_LAST}, {31'd0, e[16]});
                end
            end
            stall_q    = TX_VALID && !TX_READY;
            stall_data = TX_DATA;
            stall_last = TX_LAST;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial forever begin
        @(posedge CK50);
        #1;
        TX_READY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CK50);
        #1;
    endtask

    task automatic add_words(input int n);
        logic [11:0] w;
        pw = {};
        for (int i = 0; i < n; i++) begin
            w = 12'($urandom);
            pw.push_back(w);
            fifo.push_back(w);
        end
    endtask

    // Build expected packets for pw, split at MAXW words per packet.
    task automatic expect_pkts();
        int          i;
        int          n;
        logic [15:0] c;
        logic [15:0] d;
        i = 0;
        while (i < pw.size()) begin
            n = (pw.size() - i > MAXW) ? MAXW : pw.size() - i;
            d = {8'hA5, exp_seq};
            exp_q.push_back({1'b0, d});
            c = d;
            for (int k = 0; k < n; k++) begin
                d = {4'h0, pw[i+k]};
                exp_q.push_back({1'b0, d});
                c = c ^ d;
            end
            d = {4'hE, 12'(n)};
            exp_q.push_back({1'b0, d});
            c = c ^ d;
            exp_q.push_back({1'b1, c});
            exp_seq = exp_seq + 8'd1;
            i += n;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            wait_cycles(1);
            done = (exp_q.size() == 0) && !BUSY && (fifo.size() == 0);
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, TX_VALID}, 32'd0);
        check({tag, "_data"}, {16'd0, TX_DATA}, 32'd0);
        check({tag, "_last"}, {31'd0, TX_LAST}, 32'd0);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_seq"}, {24'd0, SEQ}, 32'd0);
        check({tag, "_rdreq"}, {31'd0, FIFO_RDREQ}, 32'd0);
    endtask

    initial begin
        logic done;

        // Reset values
        RST = 1'b1;
        wait_cycles(3);
        check_idle_outputs("reset");
        RST = 1'b0;
        wait_cycles(2);

        // Basic three-word packet with known checksum
        ENABLE = 1'b1;
        fifo.push_back(12'h001);
        fifo.push_back(12'h002);
        fifo.push_back(12'hFFF);
        exp_q.push_back({1'b0, 16'hA500});
        exp_q.push_back({1'b0, 16'h0001});
        exp_q.push_back({1'b0, 16'h0002});
        exp_q.push_back({1'b0, 16'h0FFF});
        exp_q.push_back({1'b0, 16'hE003});
        exp_q.push_back({1'b1, 16'h4AFF});
        exp_seq = 8'h01;
        wait_drain("pkt_basic_done", 200);
        wait_cycles(2 * TMO);
        check("basic_seq", {24'd0, SEQ}, 32'd1);
        check("basic_quiet", {31'd0, BUSY}, 32'd0);

        // Ten preloaded words: two full packets then a timeout-closed pair
        add_words(10);
        expect_pkts();
        wait_drain("pkt_max_done", 400);

        // Random sink backpressure over 1000 words
        rand_rdy = 1'b1;
        add_words(1000);
        expect_pkts();
        wait_drain("pkt_random_done", 30000);
        rand_rdy = 1'b0;
        wait_cycles(2);

        // Reset during DATA after two words have been sent
        add_words(4);
        exp_q.push_back({1'b0, 8'hA5, exp_seq});
        exp_q.push_back({5'b0, pw[0]});
        exp_q.push_back({5'b0, pw[1]});
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            wait_cycles(1);
            done = (exp_q.size() == 0);
        end
        check("rst_two_words_sent", {31'd0, done}, 32'd1);
        mon_en = 1'b0;
        RST = 1'b1;
        wait_cycles(1);
        check_idle_outputs("midrst");
        RST = 1'b0;
        fifo.delete();
        exp_q.delete();
        exp_seq = 8'h00;
        wait_cycles(2);
        mon_en = 1'b1;
        add_words(1);
        expect_pkts();
        wait_drain("pkt_after_rst_done", 200);

        // 256 single-word packets: sequence wraps through FF to 00
        for (int p = 0; p < 256; p++) begin
            add_words(1);
            expect_pkts();
            wait_drain("pkt_wrap_done", 200);
        end
        check("wrap_seq", {24'd0, SEQ}, {24'd0, exp_seq});

        // ENABLE dropped mid-packet
        add_words(3);
        expect_pkts();
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            wait_cycles(1);
            done = (exp_q.size() <= 5);
        end
        check("en_header_sent", {31'd0, done}, 32'd1);
        ENABLE = 1'b0;
        wait_drain("pkt_en_low_done", 200);
        add_words(2);
        wait_cycles(30);
        check("en_low_busy", {31'd0, BUSY}, 32'd0);
        check("en_low_fifo_untouched", fifo.size(), 32'd2);
        expect_pkts();
        ENABLE = 1'b1;
        wait_drain("pkt_en_high_done", 200);
        check("final_seq", {24'd0, SEQ}, {24'd0, exp_seq});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
